fsm_seq_checker: RTL and testbench
==================================

// Module: fsm_seq_checker
// PURPOSE
// Sequence checker, the observing end of the START -> OUT_SIG_1 -> OUT_SIG_2 handshake.
// - Issues nothing; samples START, SIG_1 and SIG_2 on every clock edge.
// - Flags a DONE pulse for each complete, correctly ordered sequence.
// - Flags ERR with a code for spurious, out-of-order or timed-out sequences.
// - Keeps a saturating count of good sequences. Sits beside the sequencer FSM in the test top.
// PARAMETERS
// TIMEOUT  8  max sampled edges waited in any WAIT_* state before timeout error (>=2)
// CNT_W    8  width of SEQ_CNT
// PORTS
// CLK      in   1      single clock; all logic on posedge CLK
// RESET    in   1      synchronous, active-high reset
// START    in   1      start request seen by the sequencer
// SIG_1    in   1      sequencer OUT_SIG_1
// SIG_2    in   1      sequencer OUT_SIG_2
// BUSY     out  1      1 while state != IDLE
// DONE     out  1      one-cycle pulse: sequence completed correctly
// ERR      out  1      one-cycle pulse: protocol violation
// ERR_CODE out  2      code of last error: 1 spurious, 2 timeout, 3 order; held until next ERR
// SEQ_CNT  out  CNT_W  good-sequence count, saturates at all-ones
// BEHAVIOUR
// - Reset (RESET=1 at an edge): state=IDLE, timer=0, BUSY=0, DONE=0, ERR=0, ERR_CODE=0, SEQ_CNT=0.
// - Reset has priority over everything, including mid-sequence; no DONE or ERR is produced by reset.
// - All outputs are registered. DONE and ERR are high only in the cycle after the deciding edge.
// - The timer is cleared on every state change. In a WAIT_* state, when the exit condition is false at an edge:
//   - timer==TIMEOUT-1: ERR with code 2, next state RECOVER.
//   - otherwise: timer+1.
// States and transitions (evaluated at each edge, top rule wins):
// - IDLE:
//   - SIG_1|SIG_2: ERR code 1, go to RECOVER.
//   - elsif START: go to WAIT_S1.
// - WAIT_S1:
//   - SIG_2=1 (with or without SIG_1): ERR code 3, go to RECOVER.
//   - elsif SIG_1=1: go to WAIT_S2.
//   - else: timeout rule.
// - WAIT_S2:
//   - SIG_1=0: ERR code 3, go to RECOVER.
//   - elsif SIG_2=1: go to WAIT_CLR.
//   - else: timeout rule.
// - WAIT_CLR:
//   - SIG_1=0 & SIG_2=0: DONE, SEQ_CNT+1 (saturating), go to IDLE.
//   - else: timeout rule. Either signal may fall first.
// - RECOVER:
//   - SIG_1=0 & SIG_2=0: go to IDLE. No timeout applies and no further ERR is raised.
// - START outside IDLE is ignored. START held high in IDLE starts a new sequence.
// - Unused state encodings: go to IDLE at the next edge with no outputs; SEQ_CNT is unchanged.
// - DONE and ERR are never high in the same cycle.
// - Nominal sequencer timing, with START sampled at edge k:
//   - k+1: WAIT_S1.
//   - k+2: SIG_1=1, go to WAIT_S2.
//   - k+3: SIG_1=SIG_2=1, go to WAIT_CLR.
//   - k+4: both 0, DONE high during the following cycle.
// TESTING
// 1. Nominal: START=1 at edge 0; SIG_1=1 at edges 2-3; SIG_2=1 at edge 3. -> DONE=1 after edge 4 only, SEQ_CNT=1, ERR never.
// 2. Timeout: START at edge 0; SIG_1 and SIG_2 held 0. -> ERR=1 with ERR_CODE=2 after edge 8 (TIMEOUT=8); BUSY=0 after edge 9.
// 3. Spurious: in IDLE, SIG_2=1 with no START. -> ERR code 1 next cycle; stays in RECOVER until SIG_2=0, then IDLE; SEQ_CNT unchanged.
// 4. Order: after START, SIG_1 and SIG_2 rise together. -> ERR code 3; a later nominal sequence gives DONE and SEQ_CNT+1.
// 5. Reset mid-sequence: RESET=1 at the edge where state is WAIT_S2. -> all outputs 0 next cycle, no DONE/ERR; next nominal sequence counts 1.
// 6. Saturation: CNT_W=2, six nominal sequences back-to-back. -> SEQ_CNT 1,2,3,3,3,3; DONE pulses six times.

Source files
------------

// File: rtl/fsm_seq_checker.sv
// Observer for the START -> SIG_1 -> SIG_2 handshake: pulses DONE on a clean
// sequence, ERR with a code on protocol violations, and counts good sequences.
module fsm_seq_checker #(
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             SIG_1,
    input  logic             SIG_2,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [1:0]       ERR_CODE,
    output logic [CNT_W-1:0] SEQ_CNT
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_S1  = 3'd1,
        WAIT_S2  = 3'd2,
        WAIT_CLR = 3'd3,
        RECOVER  = 3'd4
    } state_t;

    state_t           r_state;
    logic [TW-1:0]    r_timer;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tmo;

    assign w_tmo = (r_timer == TMAX);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_cnt      <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (SIG_1 | SIG_2) begin
                        r_state    <= RECOVER;
                        r_busy     <= 1'b1;
                        r_err      <= 1'b1;
                        r_err_code <= 2'd1;
                        r_timer    <= '0;
                    end else if (START) begin
                        r_state <= WAIT_S1;
                        r_busy  <= 1'b1;
                        r_timer <= '0;
                    end
                end
                WAIT_S1: begin
                    if (SIG_2) begin
                        r_state    <= RECOVER;
                        r_err      <= 1'b1;
                        r_err_code <= 2'd3;
                        r_timer    <= '0;
                    end else if (SIG_1) begin
                        r_state <= WAIT_S2;
                        r_timer <= '0;
                    end else if (w_tmo) begin
                        r_state    <= RECOVER;
                        r_err      <= 1'b1;
                        r_err_code <= 2'd2;
                        r_timer    <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                WAIT_S2: begin
                    if (!SIG_1) begin
                        r_state    <= RECOVER;
                        r_err      <= 1'b1;
                        r_err_code <= 2'd3;
                        r_timer    <= '0;
                    end else if (SIG_2) begin
                        r_state <= WAIT_CLR;
                        r_timer <= '0;
                    end else if (w_tmo) begin
                        r_state    <= RECOVER;
                        r_err      <= 1'b1;
                        r_err_code <= 2'd2;
                        r_timer    <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                WAIT_CLR: begin
                    if (!SIG_1 && !SIG_2) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_timer <= '0;
                        if (r_cnt != '1)
                            r_cnt <= r_cnt + 1'b1;
                    end else if (w_tmo) begin
                        r_state    <= RECOVER;
                        r_err      <= 1'b1;
                        r_err_code <= 2'd2;
                        r_timer    <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RECOVER: begin
                    // Waits indefinitely for the bus to go quiet; no timeout here.
                    if (!SIG_1 && !SIG_2) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_timer <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign ERR      = r_err;
    assign ERR_CODE = r_err_code;
    assign SEQ_CNT  = r_cnt;

endmodule

// File: tb/tb_fsm_seq_checker.sv
// Directed-vector bench for fsm_seq_checker (TIMEOUT=8, CNT_W=2 to reach saturation).
module tb_fsm_seq_checker;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic       SIG_1;
    logic       SIG_2;
    logic       BUSY;
    logic       DONE;
    logic       ERR;
    logic [1:0] ERR_CODE;
    logic [1:0] SEQ_CNT;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    fsm_seq_checker #(
        .TIMEOUT (8),
        .CNT_W   (2)
    ) u_dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .SIG_1    (SIG_1),
        .SIG_2    (SIG_2),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR),
        .ERR_CODE (ERR_CODE),
        .SEQ_CNT  (SEQ_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply inputs, take one rising edge, then settle before sampling.
    task automatic drive(input logic rst, input logic st, input logic s1, input logic s2);
        RESET = rst;
        START = st;
        SIG_1 = s1;
        SIG_2 = s2;
        @(posedge CLK);
        #1;
    endtask

    task automatic nominal(input string tag, input int unsigned exp_cnt);
        drive(0, 1, 0, 0);
        check({tag, "_busy_e0"}, BUSY, 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 1);
        check({tag, "_done_e3"}, DONE, 0);
        check({tag, "_busy_e3"}, BUSY, 1);
        drive(0, 0, 0, 0);
        check({tag, "_done_e4"}, DONE, 1);
        check({tag, "_err_e4"}, ERR, 0);
        check({tag, "_busy_e4"}, BUSY, 0);
        check({tag, "_cnt"}, SEQ_CNT, exp_cnt);
        drive(0, 0, 0, 0);
        check({tag, "_done_clr"}, DONE, 0);
    endtask

    initial begin
        RESET = 1'b1;
        START = 1'b0;
        SIG_1 = 1'b0;
        SIG_2 = 1'b0;
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_err", ERR, 0);
        check("rst_code", ERR_CODE, 0);
        check("rst_cnt", SEQ_CNT, 0);

        // 1. Nominal sequence
        drive(0, 0, 0, 0);
        nominal("nom", 1);

        // 2. Timeout: START then silence; ERR after edge 8
        drive(0, 1, 0, 0);
        for (int unsigned e = 1; e <= 7; e++) begin
            drive(0, 0, 0, 0);
            check("tmo_noerr", ERR, 0);
        end
        drive(0, 0, 0, 0);
        check("tmo_err", ERR, 1);
        check("tmo_code", ERR_CODE, 2);
        check("tmo_busy_e8", BUSY, 1);
        drive(0, 0, 0, 0);
        check("tmo_err_clr", ERR, 0);
        check("tmo_busy_e9", BUSY, 0);

        // 3. Spurious SIG_2 in IDLE
        drive(0, 0, 0, 1);
        check("spur_err", ERR, 1);
        check("spur_code", ERR_CODE, 1);
        check("spur_busy", BUSY, 1);
        drive(0, 1, 0, 1);
        check("spur_hold_err", ERR, 0);
        check("spur_hold_busy", BUSY, 1);
        drive(0, 0, 0, 0);
        check("spur_idle", BUSY, 0);
        check("spur_cnt", SEQ_CNT, 1);
        check("spur_code_held", ERR_CODE, 1);

        // 4. Order violation, then a good sequence
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 1);
        check("ord_err", ERR, 1);
        check("ord_code", ERR_CODE, 3);
        check("ord_done", DONE, 0);
        drive(0, 0, 0, 0);
        check("ord_idle", BUSY, 0);
        nominal("ord_nom", 2);
        check("ord_code_held", ERR_CODE, 3);

        // 5. Reset while in WAIT_S2
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 0);
        check("mrst_busy_pre", BUSY, 1);
        drive(1, 0, 1, 1);
        check("mrst_busy", BUSY, 0);
        check("mrst_done", DONE, 0);
        check("mrst_err", ERR, 0);
        check("mrst_code", ERR_CODE, 0);
        check("mrst_cnt", SEQ_CNT, 0);
        drive(0, 0, 0, 0);
        nominal("mrst_nom", 1);

        // 6. Saturation with CNT_W=2
        drive(1, 0, 0, 0);
        RESET = 1'b0;
        nominal("sat1", 1);
        nominal("sat2", 2);
        nominal("sat3", 3);
        nominal("sat4", 3);
        nominal("sat5", 3);
        nominal("sat6", 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
